// File: rtl/VX_rop_pkg.sv
// Shared ROP CSR types: arbiter state encoding, the latched request record
// and the wrap-around index helper used by the round-robin scan.
package VX_rop_pkg;

   localparam int ROP_CSR_ADDR_WIDTH = 12;
   localparam int ROP_CSR_DATA_WIDTH = 32;
   localparam int ROP_CSR_UUID_WIDTH = 44;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } rop_csr_arb_state_t;

   typedef struct packed {
      logic                          write;
      logic [ROP_CSR_ADDR_WIDTH-1:0] addr;
      logic [ROP_CSR_DATA_WIDTH-1:0] data;
      logic [ROP_CSR_UUID_WIDTH-1:0] uuid;
   } rop_csr_req_t;

   function automatic int rr_wrap(input int base, input int offset, input int n);
      return (base + offset) % n;
   endfunction

endpackage

// File: rtl/rop_csr_arbiter_if.sv
// Requester-side and CSR-bank-side signals of the ROP CSR arbiter; the
// arbiter takes the slave view, the surrounding cores/bank the master view.
interface rop_csr_arbiter_if #(
   parameter int NUM_REQS   = 4,
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int UUID_WIDTH = 44
);
   logic [NUM_REQS-1:0]                 req_valid;
   logic [NUM_REQS-1:0]                 req_write;
   logic [NUM_REQS-1:0][ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQS-1:0][DATA_WIDTH-1:0] req_data;
   logic [NUM_REQS-1:0][UUID_WIDTH-1:0] req_uuid;
   logic [NUM_REQS-1:0]                 req_ready;
   logic [NUM_REQS-1:0]                 rsp_valid;
   logic [DATA_WIDTH-1:0]               rsp_data;

   logic                  csr_valid;
   logic                  csr_write;
   logic [ADDR_WIDTH-1:0] csr_addr;
   logic [DATA_WIDTH-1:0] csr_data;
   logic [UUID_WIDTH-1:0] csr_uuid;
   logic                  csr_ready;
   logic                  csr_rsp_valid;
   logic [DATA_WIDTH-1:0] csr_rsp_data;

   modport slave (
      input  req_valid, req_write, req_addr, req_data, req_uuid,
      input  csr_ready, csr_rsp_valid, csr_rsp_data,
      output req_ready, rsp_valid, rsp_data,
      output csr_valid, csr_write, csr_addr, csr_data, csr_uuid
   );

   modport master (
      output req_valid, req_write, req_addr, req_data, req_uuid,
      output csr_ready, csr_rsp_valid, csr_rsp_data,
      input  req_ready, rsp_valid, rsp_data,
      input  csr_valid, csr_write, csr_addr, csr_data, csr_uuid
   );
endinterface

// File: rtl/rop_csr_rr_sel.sv
// Combinational round-robin pick: first valid requester at or after rr_ptr,
// scanning upward with wrap.
module rop_csr_rr_sel
   import VX_rop_pkg::*;
#(
   parameter int NUM_REQS = 4,
   localparam int IDX_W   = $clog2(NUM_REQS)
) (
   input  logic [NUM_REQS-1:0] valid,
   input  logic [IDX_W-1:0]    rr_ptr,
   output logic [NUM_REQS-1:0] grant,
   output logic [IDX_W-1:0]    grant_idx
);
   logic [IDX_W-1:0] scan_idx;

   // Scan from the farthest offset down so the nearest valid index is written last.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      grant     = '0;
      grant_idx = '0;
      scan_idx  = '0;
      for (int i = NUM_REQS - 1; i >= 0; i--) begin
         scan_idx = IDX_W'(rr_wrap(int'(rr_ptr), i, NUM_REQS));
         if (valid[scan_idx]) begin
            grant           = '0;
            grant[scan_idx] = 1'b1;
            grant_idx       = scan_idx;
         end
      end
   end

endmodule

// File: rtl/rop_csr_arbiter.sv
// Round-robin arbiter sharing the ROP CSR slave port among NUM_REQS core
// slices; one transaction in flight, reads hold the grant until data returns.
module rop_csr_arbiter
   import VX_rop_pkg::*;
#(
   parameter int NUM_REQS   = 4,
   parameter int ADDR_WIDTH = ROP_CSR_ADDR_WIDTH,
   parameter int DATA_WIDTH = ROP_CSR_DATA_WIDTH,
   parameter int UUID_WIDTH = ROP_CSR_UUID_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   rop_csr_arbiter_if.slave bus,
   output logic             busy,
   output logic             err_unexp_rsp
);
   localparam int               IDX_W    = $clog2(NUM_REQS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQS - 1);

   rop_csr_arb_state_t    state;
   logic [IDX_W-1:0]      rr_ptr;
   logic [IDX_W-1:0]      owner;
   logic [IDX_W-1:0]      grant_idx;
   logic [NUM_REQS-1:0]   grant;
   logic [NUM_REQS-1:0]   rsp_valid_q;
   logic [DATA_WIDTH-1:0] rsp_data_q;
   logic                  csr_valid_q;
   rop_csr_req_t          req_q;

   rop_csr_rr_sel #(.NUM_REQS(NUM_REQS)) u_rr_sel (
      .valid     (bus.req_valid),
      .rr_ptr    (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Accept is combinational so the requester sees it in its grant cycle.
   assign bus.req_ready = (state == IDLE) ? grant : '0;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.csr_valid = csr_valid_q;
   assign bus.csr_write = req_q.write;
   assign bus.csr_addr  = ADDR_WIDTH'(req_q.addr);
   assign bus.csr_data  = DATA_WIDTH'(req_q.data);
   assign bus.csr_uuid  = UUID_WIDTH'(req_q.uuid);
   assign busy          = (state != IDLE);

   // NOTE: all state here updates with <= so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         rr_ptr        <= '0;
         owner         <= '0;
         req_q         <= '0;
         csr_valid_q   <= 1'b0;
         rsp_valid_q   <= '0;
         rsp_data_q    <= '0;
         err_unexp_rsp <= 1'b0;
      end else begin
         rsp_valid_q <= '0;
         // Responses are only meaningful while a read is waiting for data.
         if (bus.csr_rsp_valid && (state != WAIT)) begin
            err_unexp_rsp <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (|bus.req_valid) begin
                  req_q.write <= bus.req_write[grant_idx];
                  req_q.addr  <= ROP_CSR_ADDR_WIDTH'(bus.req_addr[grant_idx]);
                  req_q.data  <= ROP_CSR_DATA_WIDTH'(bus.req_data[grant_idx]);
                  req_q.uuid  <= ROP_CSR_UUID_WIDTH'(bus.req_uuid[grant_idx]);
                  owner       <= grant_idx;
                  rr_ptr      <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
                  csr_valid_q <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (bus.csr_ready) begin
                  csr_valid_q <= 1'b0;
                  state       <= req_q.write ? IDLE : WAIT;
               end
            end
            WAIT: begin
               if (bus.csr_rsp_valid) begin
                  rsp_data_q         <= bus.csr_rsp_data;
                  rsp_valid_q[owner] <= 1'b1;
                  state              <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rop_csr_arbiter.sv
// Self-checking bench for rop_csr_arbiter: directed scenarios plus a
// randomized phase, all compared against a transaction-level model.
module tb_rop_csr_arbiter;
   localparam int N  = 4;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int UW = 44;
   localparam int IW = $clog2(N);

   logic clk;
   logic reset;
   logic busy;
   logic err_unexp_rsp;
   int   checks;
   int   errors;

   rop_csr_arbiter_if #(.NUM_REQS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .UUID_WIDTH(UW)) bus ();

   rop_csr_arbiter #(.NUM_REQS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .UUID_WIDTH(UW)) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .busy          (busy),
      .err_unexp_rsp (err_unexp_rsp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transaction-level model: at most one transaction, tracked as a record
   // plus "accepted downstream" flag; grants picked by scanning from m_ptr.
   int            m_ptr;
   bit            m_have;
   bit            m_acc;
   int            m_owner;
   logic          m_w;
   logic [AW-1:0] m_a;
   logic [DW-1:0] m_d;
   logic [UW-1:0] m_u;
   logic [N-1:0]  m_pulse;
   logic [DW-1:0] m_rdata;
   bit            m_err;
   int            last_pick;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_have = 0; m_acc = 0; m_owner = 0;
      m_w = 0; m_a = '0; m_d = '0; m_u = '0;
      m_pulse = '0; m_rdata = '0; m_err = 0; last_pick = -1;
   endtask

   task automatic set_req(input int i, input logic v, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [UW-1:0] u);
      logic [IW-1:0] ii;
      ii = IW'(i);
      bus.req_valid[ii] = v;
      bus.req_write[ii] = w;
      bus.req_addr[ii]  = a;
      bus.req_data[ii]  = d;
      bus.req_uuid[ii]  = u;
   endtask

   task automatic clear_inputs();
      bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0;
      bus.req_data = '0; bus.req_uuid = '0;
      bus.csr_ready = 1'b0; bus.csr_rsp_valid = 1'b0; bus.csr_rsp_data = '0;
   endtask

   task automatic peek();
      #1;
   endtask

   // Called just after a negedge with inputs applied: compare, advance the
   // model across the coming posedge, return at the next negedge.
   task automatic cycle();
      int            pick;
      logic [IW-1:0] pk;
      logic [N-1:0]  exp_ready;
      #1;
      pick = -1;
      for (int off = 0; off < N && pick < 0; off++) begin
         if (bus.req_valid[IW'((m_ptr + off) % N)]) pick = (m_ptr + off) % N;
      end
      pk = IW'((pick < 0) ? 0 : pick);
      exp_ready = '0;
      if (!m_have && pick >= 0) exp_ready[pk] = 1'b1;
      check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      check("csr_valid", 64'(bus.csr_valid), 64'(m_have && !m_acc));
      check("csr_write", 64'(bus.csr_write), 64'(m_w));
      check("csr_addr", 64'(bus.csr_addr), 64'(m_a));
      check("csr_data", 64'(bus.csr_data), 64'(m_d));
      check("csr_uuid", 64'(bus.csr_uuid), 64'(m_u));
      check("rsp_valid", 64'(bus.rsp_valid), 64'(m_pulse));
      check("rsp_data", 64'(bus.rsp_data), 64'(m_rdata));
      check("busy", 64'(busy), 64'(m_have));
      check("err_unexp_rsp", 64'(err_unexp_rsp), 64'(m_err));

      if (bus.csr_rsp_valid && !(m_have && m_acc)) m_err = 1;
      m_pulse   = '0;
      last_pick = -1;
      if (!m_have) begin
         if (pick >= 0) begin
            m_have = 1; m_acc = 0; m_owner = pick; last_pick = pick;
            m_w = bus.req_write[pk]; m_a = bus.req_addr[pk];
            m_d = bus.req_data[pk];  m_u = bus.req_uuid[pk];
            m_ptr = (pick + 1) % N;
         end
      end else if (!m_acc) begin
         if (bus.csr_ready) begin
            if (m_w) m_have = 0;
            else     m_acc = 1;
         end
      end else if (bus.csr_rsp_valid) begin
         m_pulse[IW'(m_owner)] = 1'b1;
         m_rdata = bus.csr_rsp_data;
         m_have  = 0;
      end
      @(negedge clk);
   endtask

   task automatic refresh_req(input int i);
      logic [IW-1:0] ii;
      bit            fresh;
      ii = IW'(i);
      if (i == last_pick)            fresh = ($urandom_range(1) == 0);
      else if (!bus.req_valid[ii])   fresh = ($urandom_range(2) == 0);
      else                           return;
      if (i == last_pick) bus.req_valid[ii] = 1'b0;
      if (fresh) set_req(i, 1'b1, 1'(($urandom_range(1))), AW'($urandom), DW'($urandom),
                         UW'({$urandom, $urandom}));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clear_inputs();
      model_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Reset state and idle cycles
      peek();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_err", 64'(err_unexp_rsp), 64'd0);
      check("rst_rr_ptr", 64'(dut.rr_ptr), 64'd0);
      check("rst_csr_valid", 64'(bus.csr_valid), 64'd0);
      check("rst_req_ready", 64'(bus.req_ready), 64'd0);
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      cycle();
      cycle();

      // All four requesters writing continuously, csr_ready high
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, AW'(12'h100 + i), DW'(32'hA0 + i), UW'(44'h1000 + i));
      bus.csr_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         peek();
         check("wr_grant", 64'(bus.req_ready), 64'(1 << (k % N)));
         check("wr_gap", 64'(bus.csr_valid), 64'd0);
         cycle();
         peek();
         check("wr_csr_valid", 64'(bus.csr_valid), 64'd1);
         check("wr_addr", 64'(bus.csr_addr), 64'(12'h100 + k % N));
         check("wr_data", 64'(bus.csr_data), 64'(32'hA0 + k % N));
         check("wr_no_grant", 64'(bus.req_ready), 64'd0);
         cycle();
      end
      bus.req_valid = '0;

      // Requester 2 reads 0x7C2 under backpressure; others wait behind it
      set_req(2, 1'b1, 1'b0, 12'h7C2, 32'h0, 44'h2222);
      bus.csr_ready = 1'b0;
      peek();
      check("rd_grant", 64'(bus.req_ready), 64'b0100);
      cycle();
      set_req(2, 1'b0, 1'b0, 12'h0, 32'h0, 44'h0);
      for (int i = 0; i < N; i++) if (i != 2) set_req(i, 1'b1, 1'b1, AW'(12'h200 + i), DW'(32'hB0 + i), UW'(44'h3000 + i));
      for (int k = 0; k < 4; k++) begin
         if (k == 3) bus.csr_ready = 1'b1;
         peek();
         check("rd_hold_valid", 64'(bus.csr_valid), 64'd1);
         check("rd_hold_addr", 64'(bus.csr_addr), 64'h7C2);
         check("rd_hold_write", 64'(bus.csr_write), 64'd0);
         check("rd_hold_no_grant", 64'(bus.req_ready), 64'd0);
         cycle();
      end
      for (int k = 0; k < 4; k++) begin
         if (k == 3) begin
            bus.csr_rsp_valid = 1'b1;
            bus.csr_rsp_data  = 32'hDEADBEEF;
         end
         peek();
         check("rd_wait_no_grant", 64'(bus.req_ready), 64'd0);
         check("rd_wait_busy", 64'(busy), 64'd1);
         check("rd_wait_no_rsp", 64'(bus.rsp_valid), 64'd0);
         cycle();
      end
      bus.csr_rsp_valid = 1'b0;
      peek();
      check("rd_rsp_valid", 64'(bus.rsp_valid), 64'b0100);
      check("rd_rsp_data", 64'(bus.rsp_data), 64'hDEADBEEF);
      check("rd_next_grant", 64'(bus.req_ready), 64'b1000);
      cycle();
      set_req(3, 1'b0, 1'b0, 12'h0, 32'h0, 44'h0);
      peek();
      check("rd_rsp_one_cycle", 64'(bus.rsp_valid), 64'd0);
      check("rd_next_addr", 64'(bus.csr_addr), 64'h203);
      cycle();
      peek();
      check("wrap_grant0", 64'(bus.req_ready), 64'b0001);
      cycle();
      bus.req_valid = '0;
      cycle();

      // Only requester 3 valid while rr_ptr is 1
      set_req(3, 1'b1, 1'b1, 12'h3F0, 32'h33, 44'h4444);
      peek();
      check("solo_ptr_before", 64'(dut.rr_ptr), 64'd1);
      check("solo_grant", 64'(bus.req_ready), 64'b1000);
      cycle();
      bus.req_valid = '0;
      check("solo_ptr_after", 64'(dut.rr_ptr), 64'd0);
      cycle();

      // Stray response while idle
      bus.csr_rsp_valid = 1'b1;
      bus.csr_rsp_data  = 32'h12345678;
      cycle();
      bus.csr_rsp_valid = 1'b0;
      peek();
      check("stray_no_rsp", 64'(bus.rsp_valid), 64'd0);
      check("stray_err", 64'(err_unexp_rsp), 64'd1);
      repeat (3) cycle();
      check("stray_err_sticky", 64'(err_unexp_rsp), 64'd1);

      // Asynchronous reset while a read waits for data
      set_req(1, 1'b1, 1'b0, 12'h055, 32'h0, 44'h5555);
      bus.csr_ready = 1'b1;
      cycle();
      bus.req_valid = '0;
      cycle();
      peek();
      check("arst_busy_before", 64'(busy), 64'd1);
      cycle();
      #2;
      reset = 1'b1;
      #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_csr_valid", 64'(bus.csr_valid), 64'd0);
      check("arst_err_cleared", 64'(err_unexp_rsp), 64'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      bus.csr_rsp_valid = 1'b1;
      bus.csr_rsp_data  = 32'hCAFEF00D;
      cycle();
      bus.csr_rsp_valid = 1'b0;
      peek();
      check("arst_late_no_rsp", 64'(bus.rsp_valid), 64'd0);
      check("arst_late_err", 64'(err_unexp_rsp), 64'd1);
      cycle();

      // Randomized traffic from a clean reset
      reset = 1'b1;
      clear_inputs();
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) refresh_req(i);
         bus.csr_ready     = ($urandom_range(2) != 0);
         bus.csr_rsp_valid = (m_have && m_acc) ? ($urandom_range(2) == 0) : 1'b0;
         bus.csr_rsp_data  = DW'($urandom);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rop_csr_arbiter.md
# rop_csr_arbiter

Shares the single ROP CSR slave port among `NUM_REQS` requesters (one per issuing core pipeline slice) using round-robin arbitration. Each granted request is registered and presented downstream under a valid/ready handshake. Reads hold the arbiter until their data returns, and the data is routed back to the requester that issued them. The block sits between the core CSR units and the ROP CSR bank.

## Interface
- `NUM_REQS`, 4, number of requesters (≥2)
- `ADDR_WIDTH`, 12, CSR address width
- `DATA_WIDTH`, 32, CSR data width
- `UUID_WIDTH`, 44, instruction uuid width
- `clk` in 1 — clock
- `reset` in 1 — reset; **one clock; reset is asynchronous and active-high**
- `req_valid` in NUM_REQS — per-requester request valid
- `req_write` in NUM_REQS — 1 = write, 0 = read
- `req_addr` in NUM_REQS×ADDR_WIDTH — CSR address
- `req_data` in NUM_REQS×DATA_WIDTH — write data
- `req_uuid` in NUM_REQS×UUID_WIDTH — uuid for trace
- `req_ready` out NUM_REQS — one-hot accept
- `rsp_valid` out NUM_REQS — one-hot read response, one-cycle pulse
- `rsp_data` out DATA_WIDTH — shared read data, valid with `rsp_valid`
- `csr_valid` out 1 — downstream request valid
- `csr_write`, `csr_addr`, `csr_data`, `csr_uuid` out 1/ADDR_WIDTH/DATA_WIDTH/UUID_WIDTH — downstream request fields
- `csr_ready` in 1 — downstream accept
- `csr_rsp_valid` in 1 — downstream read data valid
- `csr_rsp_data` in DATA_WIDTH — downstream read data
- `busy` out 1 — state ≠ IDLE
- `err_unexp_rsp` out 1 — sticky; a response arrived outside WAIT

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE**
  - If any `req_valid` is set, select grant g = first valid index at or after `rr_ptr`, scanning with wrap.
  - Assert `req_ready[g]` combinationally in the same cycle.
  - Latch g's write/addr/data/uuid and `owner`=g.
  - Set `rr_ptr` ← (g+1) mod NUM_REQS.
  - Go to ISSUE.
- **ISSUE**
  - `csr_valid`=1; fields are stable until accepted.
  - On `csr_ready`: a write goes to IDLE; a read goes to WAIT.
- **WAIT**
  - On `csr_rsp_valid`: register `rsp_data` ← `csr_rsp_data` and pulse `rsp_valid[owner]` on the next cycle.
  - Go to IDLE.
- `req_ready` is 0 in ISSUE and WAIT. There is at most one outstanding transaction.
- `csr_rsp_valid` in IDLE or ISSUE is dropped and sets `err_unexp_rsp`. Only reset clears it.
- `rr_ptr` advances only on a grant, never on idle cycles.
- Reset mid-transaction:
  - All state clears immediately.
  - Any in-flight downstream read response arriving after reset sets `err_unexp_rsp`.
- **Reset values:** state=IDLE, `rr_ptr`=0, `csr_valid`=0, `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, latched fields=0, `busy`=0, `err_unexp_rsp`=0.

## Timing
- Grant in cycle T puts `csr_valid`=1 at T+1.
- Write with `csr_ready` at T+1: returns to IDLE at T+2, where the next grant is possible. Sustained write throughput is 1 per 2 cycles.
- Read with `csr_ready` at T+1 and `csr_rsp_valid` at T+k (k≥2): `rsp_valid` at T+k+1, next grant at T+k+1.
- `csr_rsp_valid` in the same cycle the FSM enters WAIT is not possible; a response is accepted from the first WAIT cycle onward.
- `rsp_valid` and `req_ready` can both be high in the same cycle, for different or the same requester.
- Backpressure: `csr_ready`=0 holds ISSUE indefinitely with all outputs stable.

## Structure
- Shared package `VX_rop_pkg` holds:
  - state enum `rop_csr_arb_state_t` {IDLE, ISSUE, WAIT}
  - packed struct `rop_csr_req_t` {write, addr, data, uuid}
- Sub-module `rop_csr_rr_sel`: combinational round-robin priority select. Inputs: valid vector and `rr_ptr`. Outputs: one-hot grant and index.
- `DBG_TRACE_ROP` trace prints grant index, addr, and uuid on accept.

## Test plan
- Reset, then idle: all outputs 0; `busy`=0; `rr_ptr`=0.
- All 4 requesters write continuously, `csr_ready`=1:
  - Grants follow 0,1,2,3,0.
  - One `csr_valid` every 2 cycles.
  - `csr_addr`/`csr_data` match the granted requester.
- Requester 2 reads addr 0x7C2; `csr_ready` is held 0 for 3 cycles; `csr_rsp_data`=0xDEADBEEF arrives 4 cycles after accept:
  - `csr_valid` stays stable throughout.
  - `rsp_valid`=0b0100 with `rsp_data`=0xDEADBEEF for exactly one cycle.
  - No grants occur meanwhile.
- Only requester 3 is valid while `rr_ptr`=1: grant 3 in the same cycle; then `rr_ptr`=0.
- `csr_rsp_valid` pulses while IDLE: no `rsp_valid`; `err_unexp_rsp`=1 and stays set until reset.
- Async reset asserted mid-WAIT: `busy` and `csr_valid` drop without a clock edge; a later `csr_rsp_valid` produces no `rsp_valid`.
